tdm_demux_4: RTL and testbench
==============================

Name: tdm_demux_4

Overview:
Receive end of the 4-slot time-division link whose transmit end is a 4:1 mux driven by a rotating 2-bit select. Samples one serial slot per sample strobe and aligns to a frame marker on slot 0. Rebuilds the four parallel lanes and presents them as one registered word with a valid pulse. Sits between the serial link input and the parallel consumer logic on the Basys3 board.

Parameters:
WIDTH, 1, bits carried per slot (the lane width); legal values are 1 or more.

Ports:
clk  input  1  system clock; all logic is rising-edge.
rst_n  input  1  asynchronous active-low reset.
din  input  WIDTH  serial slot data from the link.
sample_en  input  1  one-cycle strobe: din and frame_sync are valid this cycle.
frame_sync  input  1  high together with sample_en when din carries slot 0.
data_out  output  4*WIDTH  reconstructed word: slot k is at bits [k*WIDTH +: WIDTH].
valid  output  1  one-cycle pulse when data_out is updated.
sel_out  output  2  slot index expected at the next sample_en.
locked  output  1  high while frame-aligned.
sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset values (async on rst_n low): data_out=0, valid=0, sel_out=0, locked=0, sync_err=0. Shadow registers are cleared and the state is HUNT.
- The state machine has two states, HUNT and LOCKED. The slot counter is 2 bits and wraps from 3 to 0.
- Cycles without sample_en: no state change. valid and sync_err are 0.
- HUNT with sample_en=1 and frame_sync=1: shadow[0]<=din, slot<=1, state<=LOCKED, locked<=1.
- HUNT with sample_en=1 and frame_sync=0: the sample is dropped and the state stays HUNT. No error is raised.
- LOCKED, slot=0, sample_en=1, frame_sync=1: shadow[0]<=din, slot<=1.
- LOCKED, slot=0, sample_en=1, frame_sync=0 (missing marker):
  - sync_err pulses.
  - State<=HUNT, locked<=0, slot<=0.
  - The sample is dropped.
- LOCKED, slot in 1..3, sample_en=1, frame_sync=1 (early marker):
  - sync_err pulses.
  - The partial frame is discarded.
  - The sample is taken as slot 0: shadow[0]<=din, slot<=1, and the state stays LOCKED.
- LOCKED, slot in 1..2, frame_sync=0: shadow[slot]<=din, slot<=slot+1.
- LOCKED, slot=3, frame_sync=0: data_out<={din,shadow[2],shadow[1],shadow[0]}, valid<=1, slot<=0.
- Latency: data_out and valid become visible on the clock edge after the slot-3 sample cycle.
- data_out holds its value until the next complete frame. It is not cleared on lock loss.
- sel_out always equals the internal slot counter, registered.
- sample_en on consecutive cycles is legal. Back-to-back frames produce one valid pulse every 4 strobes.
- Reset asserted mid-frame: the partial frame is lost and all outputs return to reset values immediately. After rst_n deasserts, the block restarts in HUNT.
- The block has no combinational path from inputs to outputs.

Test Plan:
- Reset then frame, WIDTH=1: strobes (sync,din) = (1,1),(0,0),(0,1),(0,1). Required: data_out=4'b1101, valid high exactly one cycle after the 4th strobe, locked=1, sel_out sequence 1,2,3,0.
- Hunt: three strobes with sync=0, then a correct frame carrying 0,1,1,0. Required: locked stays 0 through the first three strobes, no sync_err, data_out=4'b0110.
- Missing marker: after a good frame, a strobe with slot=0 and sync=0. Required: sync_err pulse, locked=0, data_out keeps its old value, no valid pulse.
- Early marker at slot 2: then a full frame 1,1,0,0. Required: one sync_err pulse, locked stays 1, data_out=4'b0011, no valid pulse for the aborted frame.
- Gapped strobes: a frame 1,0,0,1 with 5 idle cycles between strobes. Required: data_out=4'b1001 and exactly one valid pulse.
- Async reset after slot 1 of a frame: outputs go to 0 without a clock edge. The next full frame 1,1,1,1 yields data_out=4'b1111.
- WIDTH=4: slots 0xA,0x5,0xF,0x0. Required: data_out=16'h0F5A.

Source files
------------

// File: rtl/tdm_demux_4.sv
// Receive side of a 4-slot TDM link: aligns on the slot-0 frame marker, collects
// the four lanes and publishes them as one registered word with a valid pulse.
module tdm_demux_4 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   din,
  input  logic               sample_en,
  input  logic               frame_sync,
  output logic [4*WIDTH-1:0] data_out,
  output logic               valid,
  output logic [1:0]         sel_out,
  output logic               locked,
  output logic               sync_err
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [1:0]           slot_q, slot_d;
  logic [WIDTH-1:0]     shadow0_q, shadow0_d;
  logic [WIDTH-1:0]     shadow1_q, shadow1_d;
  logic [WIDTH-1:0]     shadow2_q, shadow2_d;
  logic [4*WIDTH-1:0]   data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 locked_q, locked_d;
  logic                 sync_err_q, sync_err_d;

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    shadow0_d  = shadow0_q;
    shadow1_d  = shadow1_q;
    shadow2_d  = shadow2_q;
    data_d     = data_q;
    locked_d   = locked_q;
    valid_d    = 1'b0;
    sync_err_d = 1'b0;

    if (sample_en) begin
      case (state_q)
        HUNT: begin
          // Unmarked samples are simply ignored while searching for alignment.
          if (frame_sync) begin
            shadow0_d = din;
            slot_d    = 2'd1;
            state_d   = LOCKED;
            locked_d  = 1'b1;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            // A marker anywhere but slot 0 restarts the frame from this sample.
            sync_err_d = (slot_q != 2'd0);
            shadow0_d  = din;
            slot_d     = 2'd1;
          end else if (slot_q == 2'd0) begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
            locked_d   = 1'b0;
            slot_d     = 2'd0;
          end else if (slot_q == 2'd3) begin
            data_d  = {din, shadow2_q, shadow1_q, shadow0_q};
            valid_d = 1'b1;
            slot_d  = 2'd0;
          end else begin
            if (slot_q == 2'd1) shadow1_d = din;
            else                shadow2_d = din;
            slot_d = slot_q + 2'd1;
          end
        end
        default: begin
          state_d  = HUNT;
          locked_d = 1'b0;
          slot_d   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      slot_q     <= 2'd0;
      shadow0_q  <= '0;
      shadow1_q  <= '0;
      shadow2_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      shadow0_q  <= shadow0_d;
      shadow1_q  <= shadow1_d;
      shadow2_q  <= shadow2_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign data_out = data_q;
  assign valid    = valid_q;
  assign sel_out  = slot_q;
  assign locked   = locked_q;
  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_4.sv
// Bench for tdm_demux_4: a 1-bit and a 4-bit instance share strobes and are
// compared against a queue-based frame model.
module tb_tdm_demux_4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sample_en;
  logic       frame_sync;
  logic [3:0] din4;

  logic [3:0]  d1_data;
  logic        d1_valid, d1_locked, d1_err;
  logic [1:0]  d1_sel;
  logic [15:0] dw_data;
  logic        dw_valid, dw_locked, dw_err;
  logic [1:0]  dw_sel;

  tdm_demux_4 #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din(din4[0:0]), .sample_en(sample_en),
    .frame_sync(frame_sync), .data_out(d1_data), .valid(d1_valid),
    .sel_out(d1_sel), .locked(d1_locked), .sync_err(d1_err)
  );

  tdm_demux_4 #(.WIDTH(4)) u_dutw (
    .clk(clk), .rst_n(rst_n), .din(din4), .sample_en(sample_en),
    .frame_sync(frame_sync), .data_out(dw_data), .valid(dw_valid),
    .sel_out(dw_sel), .locked(dw_locked), .sync_err(dw_err)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: lanes gathered so far in the current frame.
  bit         m_locked;
  logic [3:0] m_q[$];
  logic [15:0] m_data;
  bit         m_valid, m_err;
  logic [1:0] m_sel;

  logic [29:0] obs;
  assign obs = {dw_data, d1_data, dw_valid, d1_valid, dw_err, d1_err,
                dw_locked, d1_locked, dw_sel, d1_sel};

  function automatic logic [29:0] exp_vec();
    logic [3:0] n;
    for (int k = 0; k < 4; k++) n[k] = m_data[4*k];
    return {m_data, n, m_valid, m_valid, m_err, m_err, m_locked, m_locked, m_sel, m_sel};
  endfunction

  task automatic model_reset();
    m_locked = 0; m_q.delete(); m_data = '0; m_valid = 0; m_err = 0; m_sel = 2'd0;
  endtask

  task automatic strobe(input bit s, input logic [3:0] d);
    sample_en = 1'b1; frame_sync = s; din4 = d;
    @(posedge clk); #1;
    sample_en = 1'b0; frame_sync = 1'($urandom_range(0, 1)); din4 = 4'($urandom);
    m_valid = 0; m_err = 0;
    if (!m_locked) begin
      if (s) begin m_locked = 1; m_q = {d}; end
    end else if (s) begin
      if (m_q.size() != 0) m_err = 1;
      m_q = {d};
    end else if (m_q.size() == 0) begin
      m_err = 1; m_locked = 0;
    end else begin
      m_q.push_back(d);
      if (m_q.size() == 4) begin
        m_data = {m_q[3], m_q[2], m_q[1], m_q[0]};
        m_valid = 1;
        m_q.delete();
      end
    end
    m_sel = 2'(m_q.size());
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
    m_valid = 0; m_err = 0;
  endtask

  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 30'h0) begin errors++; $display("FAIL async_reset: got %h want 0", obs); end
    model_reset();
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    #6;
  endtask

  task automatic test_reset();
    logic [7:0] tbl;
    rst_n = 1'b0; sample_en = 1'b0; frame_sync = 1'b0; din4 = 4'h0;
    model_reset();
    #22;
    checks++;
    if (obs !== 30'h0) begin errors++; $display("FAIL reset_state: got %h want 0", obs); end
    @(negedge clk); rst_n = 1'b1;
    tbl = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}; // (sync,din) per strobe
    for (int i = 0; i < 4; i++) begin
      strobe(tbl[7-2*i], {3'b000, tbl[6-2*i]});
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL reset_frame step %0d: got %h want %h", i, obs, exp_vec()); end
      checks++;
      if (d1_sel !== 2'(i + 1)) begin errors++; $display("FAIL reset_frame_sel step %0d: got %0d want %0d", i, d1_sel, 2'(i + 1)); end
    end
    checks++;
    if (d1_data !== 4'b1101 || dw_data !== 16'h1101 || d1_valid !== 1'b1 || d1_locked !== 1'b1) begin
      errors++; $display("FAIL reset_frame_word: got %b/%h v=%b l=%b want 1101/1101 v=1 l=1", d1_data, dw_data, d1_valid, d1_locked);
    end
    idle(1);
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL reset_frame_after: got %h want %h", obs, exp_vec()); end
  endtask

  task automatic test_hunt();
    logic [3:0] fr;
    async_reset();
    for (int i = 0; i < 3; i++) begin
      strobe(1'b0, 4'($urandom));
      checks++;
      if (obs !== exp_vec() || d1_locked !== 1'b0 || d1_err !== 1'b0) begin
        errors++; $display("FAIL hunt_drop step %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    fr = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      strobe(i == 0, {3'b000, fr[i]});
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL hunt_frame step %0d: got %h want %h", i, obs, exp_vec()); end
    end
    checks++;
    if (d1_data !== 4'b0110) begin errors++; $display("FAIL hunt_word: got %b want 0110", d1_data); end
  endtask

  task automatic test_missing_marker();
    strobe(1'b0, 4'h1);
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL missing_marker: got %h want %h", obs, exp_vec()); end
    checks++;
    if (d1_err !== 1'b1 || d1_locked !== 1'b0 || d1_valid !== 1'b0 || d1_data !== 4'b0110) begin
      errors++; $display("FAIL missing_marker_flags: got err=%b l=%b v=%b d=%b want 1 0 0 0110", d1_err, d1_locked, d1_valid, d1_data);
    end
    idle(1);
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL missing_marker_after: got %h want %h", obs, exp_vec()); end
  endtask

  task automatic test_early_marker();
    bit s_tbl[10];
    logic [3:0] d_tbl[10];
    int errs_seen, valids_seen;
    s_tbl = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 0};
    d_tbl = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0};
    errs_seen = 0; valids_seen = 0;
    for (int i = 0; i < 10; i++) begin
      strobe(s_tbl[i], d_tbl[i]);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL early_marker step %0d: got %h want %h", i, obs, exp_vec()); end
      if (i >= 4) begin errs_seen += int'(d1_err); valids_seen += int'(d1_valid); end
    end
    checks++;
    if (d1_data !== 4'b0011 || errs_seen != 1 || valids_seen != 1 || d1_locked !== 1'b1) begin
      errors++; $display("FAIL early_marker_word: got d=%b errs=%0d valids=%0d l=%b want 0011 1 1 1", d1_data, errs_seen, valids_seen, d1_locked);
    end
  endtask

  task automatic test_gapped();
    logic [3:0] fr;
    int valids_seen;
    fr = 4'b1001; valids_seen = 0;
    for (int i = 0; i < 4; i++) begin
      strobe(i == 0, {3'b000, fr[i]});
      valids_seen += int'(d1_valid);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL gapped_strobe step %0d: got %h want %h", i, obs, exp_vec()); end
      for (int g = 0; g < 5; g++) begin
        idle(1);
        valids_seen += int'(d1_valid);
      end
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL gapped_idle step %0d: got %h want %h", i, obs, exp_vec()); end
    end
    checks++;
    if (d1_data !== 4'b1001 || valids_seen != 1) begin
      errors++; $display("FAIL gapped_word: got %b valids=%0d want 1001 valids=1", d1_data, valids_seen);
    end
  endtask

  task automatic test_reset_midframe();
    strobe(1'b1, 4'h1);
    strobe(1'b0, 4'h0);
    async_reset();
    for (int i = 0; i < 4; i++) begin
      strobe(i == 0, 4'h1);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL midreset_frame step %0d: got %h want %h", i, obs, exp_vec()); end
    end
    checks++;
    if (d1_data !== 4'b1111 || dw_data !== 16'h1111) begin
      errors++; $display("FAIL midreset_word: got %b/%h want 1111/1111", d1_data, dw_data);
    end
  endtask

  task automatic test_wide();
    logic [3:0] fr[4];
    fr = '{4'hA, 4'h5, 4'hF, 4'h0};
    for (int i = 0; i < 4; i++) begin
      strobe(i == 0, fr[i]);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL wide step %0d: got %h want %h", i, obs, exp_vec()); end
    end
    checks++;
    if (dw_data !== 16'h0F5A || d1_data !== 4'b0110) begin
      errors++; $display("FAIL wide_word: got %h/%b want 0f5a/0110", dw_data, d1_data);
    end
  endtask

  task automatic test_back_to_back();
    int valids_seen;
    valids_seen = 0;
    for (int i = 0; i < 12; i++) begin
      strobe((i % 4) == 0, 4'($urandom));
      valids_seen += int'(dw_valid);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL back_to_back step %0d: got %h want %h", i, obs, exp_vec()); end
    end
    checks++;
    if (valids_seen != 3) begin errors++; $display("FAIL back_to_back_count: got %0d want 3", valids_seen); end
  endtask

  task automatic test_random();
    bit want0, s;
    for (int i = 0; i < 400; i++) begin
      want0 = (m_q.size() == 0);
      s = ($urandom_range(0, 9) == 0) ? !want0 : want0;
      strobe(s, 4'($urandom));
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL random step %0d: got %h want %h", i, obs, exp_vec()); end
      if ($urandom_range(0, 2) == 0) begin
        idle($urandom_range(1, 3));
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL random_idle step %0d: got %h want %h", i, obs, exp_vec()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_hunt();
    test_missing_marker();
    test_early_marker();
    test_gapped();
    test_reset_midframe();
    test_wide();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
